// File: rtl/adc_sample_buffer_if.sv
// Burst write bus between the ADC sample buffer and the PSRAM write controller.
// The buffer (master) requests a burst at wr_addr. The controller (slave) grants
// it once, then pops words from wr_data one per wr_pop.
interface adc_sample_buffer_if #(
    parameter int ADDR_W = 21
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_grant;
    logic              wr_pop;
    logic [15:0]       wr_data;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_grant,
        input  wr_pop
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_grant,
        output wr_pop
    );
endinterface

// File: rtl/adc_sample_buffer.sv
// ADC sample buffer: captures one 16-bit word per rising edge of adc_clk into a
// FIFO. Drains the FIFO to the PSRAM controller in fixed-length bursts at an
// incrementing, wrapping address. A run ends after num_samples strobes.
module adc_sample_buffer #(
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_LEN  = 16,
    parameter int ADDR_W     = 21,
    parameter int CNT_W      = 20
) (
    input  logic                clk_PSRAM,
    input  logic                rst_n,
    input  logic                adc_clk,
    input  logic [11:0]         adc_data,
    input  logic                adc_OTR,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    num_samples,
    adc_sample_buffer_if.master wr_bus,
    output logic                busy,
    output logic                done,
    output logic                overflow
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  BURST_P = PTR_W'(BURST_LEN);
    localparam logic [PTR_W-1:0]  ONE_P   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  BURST_C = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {C_IDLE, C_RUN, C_WAIT} cap_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_BURST} wr_state_t;

    cap_state_t        c_state_reg, c_state_next;
    wr_state_t         w_state_reg, w_state_next;

    logic              adc_clk_q_reg;
    logic              stb;
    logic [15:0]       sample_word;

    logic [CNT_W-1:0]  num_reg;
    logic [CNT_W-1:0]  strobe_cnt_reg;
    logic [CNT_W-1:0]  pushed_cnt_reg;
    logic [CNT_W-1:0]  written_cnt_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic              done_reg;
    logic              overflow_reg;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [15:0]       wr_data_reg;
    logic [15:0]       head_next;
    logic [PTR_W-1:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;

    logic              do_push;
    logic              do_drop;
    logic              do_pop;
    logic              burst_last;
    logic              run_start;
    logic              run_exit;

    // Strobe on each rising edge of the (already synchronous) ADC clock
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            adc_clk_q_reg <= 1'b0;
        end else begin
            adc_clk_q_reg <= adc_clk;
        end
    end

    assign stb         = adc_clk & ~adc_clk_q_reg;
    assign sample_word = {adc_OTR, 3'b000, adc_data};

    assign fifo_level = wr_ptr_reg - rd_ptr_reg;
    assign fifo_full  = (fifo_level == DEPTH_P);
    assign fifo_empty = (fifo_level == '0);

    // Samples only enter the FIFO during a run; a full FIFO drops the sample
    assign do_push    = (c_state_reg == C_RUN) && stb && !fifo_full;
    assign do_drop    = (c_state_reg == C_RUN) && stb && fifo_full;
    assign do_pop     = (w_state_reg == W_BURST) && wr_bus.wr_pop && !fifo_empty;
    assign burst_last = do_pop && (beat_cnt_reg == BURST_C - ONE_C);

    // Capture FSM next state: start, count strobes, wait for the drain
    always_comb begin
        c_state_next = c_state_reg;
        run_start    = 1'b0;
        run_exit     = 1'b0;
        unique case (c_state_reg)
            C_IDLE: begin
                if (start) begin
                    c_state_next = C_RUN;
                    run_start    = 1'b1;
                end
            end
            C_RUN: begin
                if (stb && (strobe_cnt_reg + ONE_C == num_reg)) begin
                    c_state_next = C_WAIT;
                end
            end
            C_WAIT: begin
                // Only whole bursts are written. With drops, a partial remainder
                // of less than one burst can stay behind; the run still ends and
                // that remainder is flushed.
                if ((w_state_reg == W_IDLE) &&
                    ((pushed_cnt_reg - written_cnt_reg) < BURST_C)) begin
                    c_state_next = C_IDLE;
                    run_exit     = 1'b1;
                end
            end
            default: c_state_next = C_IDLE;
        endcase
    end

    // Write FSM next state: request once a full burst is buffered, then stream it
    always_comb begin
        w_state_next = w_state_reg;
        unique case (w_state_reg)
            W_IDLE:  if (fifo_level >= BURST_P) w_state_next = W_REQ;
            W_REQ:   if (wr_bus.wr_grant)       w_state_next = W_BURST;
            W_BURST: if (burst_last)            w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // State registers for both FSMs
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            c_state_reg <= C_IDLE;
            w_state_reg <= W_IDLE;
        end else begin
            c_state_reg <= c_state_next;
            w_state_reg <= w_state_next;
        end
    end

    // Run bookkeeping: latched parameters, counters, address and status flags
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            num_reg         <= '0;
            strobe_cnt_reg  <= '0;
            pushed_cnt_reg  <= '0;
            written_cnt_reg <= '0;
            wr_addr_reg     <= '0;
            done_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
        end else if (run_start) begin
            num_reg         <= num_samples;
            strobe_cnt_reg  <= '0;
            pushed_cnt_reg  <= '0;
            written_cnt_reg <= '0;
            wr_addr_reg     <= base_addr;
            done_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            if ((c_state_reg == C_RUN) && stb) begin
                strobe_cnt_reg <= strobe_cnt_reg + ONE_C;
            end
            if (do_push) begin
                pushed_cnt_reg <= pushed_cnt_reg + ONE_C;
            end
            if (do_drop) begin
                overflow_reg <= 1'b1;
            end
            if (burst_last) begin
                written_cnt_reg <= written_cnt_reg + BURST_C;
                wr_addr_reg     <= wr_addr_reg + BURST_A;
            end
            if (run_exit) begin
                done_reg <= 1'b1;
            end
        end
    end

    // Beat counter within a burst
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
        end else if (w_state_reg != W_BURST || burst_last) begin
            beat_cnt_reg <= '0;
        end else if (do_pop) begin
            beat_cnt_reg <= beat_cnt_reg + ONE_C;
        end
    end

    // FIFO storage, no reset so it maps onto RAM
    always_ff @(posedge clk_PSRAM) begin
        if (do_push) begin
            mem[wr_ptr_reg[IDX_W-1:0]] <= sample_word;
        end
    end

    // Next head word; a push landing on the new head bypasses the RAM
    always_comb begin
        rd_ptr_next = do_pop ? rd_ptr_reg + ONE_P : rd_ptr_reg;
        head_next   = wr_data_reg;
        if (do_push && (rd_ptr_next == wr_ptr_reg)) begin
            head_next = sample_word;
        end else if (rd_ptr_next != wr_ptr_reg) begin
            head_next = mem[rd_ptr_next[IDX_W-1:0]];
        end
    end

    // FIFO pointers and registered head word; flushed when a run ends
    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            wr_data_reg <= '0;
        end else if (run_exit) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_P;
            end
            rd_ptr_reg  <= rd_ptr_next;
            wr_data_reg <= head_next;
        end
    end

    assign wr_bus.wr_req  = (w_state_reg == W_REQ);
    assign wr_bus.wr_addr = wr_addr_reg;
    assign wr_bus.wr_data = wr_data_reg;
    assign busy           = (c_state_reg != C_IDLE);
    assign done           = done_reg;
    assign overflow       = overflow_reg;
endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed bench for adc_sample_buffer: a table of capture runs plus
// hand-written sequences for overflow, start-while-busy and reset mid-burst.
module tb_adc_sample_buffer;
    localparam int ADDR_W = 21;
    localparam int CNT_W  = 20;
    localparam int BURST  = 16;

    logic              clk_PSRAM   = 1'b0;
    logic              rst_n       = 1'b0;
    logic              adc_clk     = 1'b0;
    logic [11:0]       adc_data    = '0;
    logic              adc_OTR     = 1'b0;
    logic              start       = 1'b0;
    logic [ADDR_W-1:0] base_addr   = '0;
    logic [CNT_W-1:0]  num_samples = '0;
    logic              busy;
    logic              done;
    logic              overflow;

    adc_sample_buffer_if #(.ADDR_W(ADDR_W)) wr_bus ();

    adc_sample_buffer #(
        .FIFO_DEPTH (64),
        .BURST_LEN  (BURST),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_PSRAM   (clk_PSRAM),
        .rst_n       (rst_n),
        .adc_clk     (adc_clk),
        .adc_data    (adc_data),
        .adc_OTR     (adc_OTR),
        .start       (start),
        .base_addr   (base_addr),
        .num_samples (num_samples),
        .wr_bus      (wr_bus),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #6 clk_PSRAM = ~clk_PSRAM;

    int checks   = 0;
    int failures = 0;

    logic [15:0]       got_data[$];
    logic [ADDR_W-1:0] got_addr[$];
    int                beats_left = 0;
    logic              grant_hold = 1'b0;
    int                req_age    = 0;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                num;
        int                first;
        int                otr_idx;
        logic [ADDR_W-1:0] exp_addr1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp_v);
        end
    endtask

    // Controller model: grant two cycles after wr_req unless held back
    initial begin
        wr_bus.wr_grant = 1'b0;
        forever begin
            @(negedge clk_PSRAM);
            if (!rst_n) begin
                wr_bus.wr_grant = 1'b0;
                req_age = 0;
            end else if (wr_bus.wr_grant) begin
                wr_bus.wr_grant = 1'b0;
                req_age = 0;
            end else if (wr_bus.wr_req && !grant_hold) begin
                req_age++;
                if (req_age >= 2) wr_bus.wr_grant = 1'b1;
            end else begin
                req_age = 0;
            end
        end
    end

    // Monitor: record the address of each granted burst and its popped words
    initial begin
        forever begin
            @(negedge clk_PSRAM);
            #1;
            if (!rst_n) begin
                beats_left = 0;
            end else if (beats_left > 0) begin
                if (wr_bus.wr_pop) begin
                    got_data.push_back(wr_bus.wr_data);
                    beats_left--;
                end
            end else if (wr_bus.wr_grant && wr_bus.wr_req) begin
                got_addr.push_back(wr_bus.wr_addr);
                beats_left = BURST;
            end
        end
    end

    function automatic logic [15:0] exp_word(input int first, input int otr_idx, input int k);
        if (k == otr_idx) return 16'h8FFF;
        return {4'b0000, 12'(first + k)};
    endfunction

    // One sample per 8 clocks (adc_clk high 4, low 4)
    task automatic drive_samples(input int n, input int first, input int otr_idx, input int release_idx);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_PSRAM);
            if (k == otr_idx) begin
                adc_data = 12'hFFF;
                adc_OTR  = 1'b1;
            end else begin
                adc_data = 12'(first + k);
                adc_OTR  = 1'b0;
            end
            adc_clk = 1'b1;
            @(negedge clk_PSRAM);
            if (k == release_idx) grant_hold = 1'b0;
            repeat (3) @(negedge clk_PSRAM);
            adc_clk = 1'b0;
            repeat (3) @(negedge clk_PSRAM);
        end
    endtask

    task automatic start_run(input logic [ADDR_W-1:0] base, input int num);
        @(negedge clk_PSRAM);
        base_addr   = base;
        num_samples = CNT_W'(num);
        start       = 1'b1;
        @(negedge clk_PSRAM);
        start       = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 4000) begin
            @(negedge clk_PSRAM);
            n++;
        end
        #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_off"}, busy, 0);
    endtask

    task automatic check_addrs(input string tag, input logic [ADDR_W-1:0] base, input int nb);
        logic [ADDR_W-1:0] exp_a;
        check({tag, "_bursts"}, got_addr.size(), nb);
        for (int i = 0; i < got_addr.size() && i < nb; i++) begin
            exp_a = base + ADDR_W'(i * BURST);
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_a);
        end
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        got_data.delete();
        got_addr.delete();
        start_run(v.base, v.num);
        #1;
        check({tag, "_busy_on"}, busy, 1);
        check({tag, "_done_clr"}, done, 0);
        drive_samples(v.num, v.first, v.otr_idx, -1);
        wait_done(tag);
        check({tag, "_ovf"}, overflow, 0);
        check_addrs(tag, v.base, v.num / BURST);
        if (got_addr.size() > 1) check({tag, "_addr_second"}, got_addr[1], v.exp_addr1);
        check({tag, "_words"}, got_data.size(), v.num);
        for (int i = 0; i < got_data.size() && i < v.num; i++) begin
            check($sformatf("%s_word%0d", tag, i), got_data[i], exp_word(v.first, v.otr_idx, i));
        end
    endtask

    initial begin
        int  n;
        logic saw_req;

        //            base          num first   otr  second-burst address
        vecs[0] = '{21'h000100,     32, 'h000,  -1, 21'h000110};
        vecs[1] = '{21'h1FFFF0,     32, 'h040,   5, 21'h000000};
        vecs[2] = '{21'h002000,     48, 'hF00,  47, 21'h002010};
        vecs[3] = '{21'h1FFFE0,     64, 'hFF0,   0, 21'h1FFFF0};
        vecs[4] = '{21'h000600,     32, 'h200,  10, 21'h000610};

        wr_bus.wr_pop = 1'b1;

        // Reset state
        repeat (3) @(negedge clk_PSRAM);
        #1;
        check("rst_wr_req",   wr_bus.wr_req,  0);
        check("rst_wr_addr",  wr_bus.wr_addr, 0);
        check("rst_wr_data",  wr_bus.wr_data, 0);
        check("rst_busy",     busy,           0);
        check("rst_done",     done,           0);
        check("rst_overflow", overflow,       0);
        rst_n = 1'b1;

        // Table of plain runs: basic, OTR packing, address wrap
        for (int vi = 0; vi < 4; vi++) begin
            run_vector(vecs[vi], $sformatf("vec%0d", vi));
        end

        // Backpressure: no grant until 70 strobes; samples 64..69 are dropped,
        // 122 words enter the FIFO, 7 bursts are written and 10 words flushed.
        got_data.delete();
        got_addr.delete();
        grant_hold = 1'b1;
        start_run(21'h004000, 128);
        drive_samples(128, 0, -1, 69);
        wait_done("ovf");
        check("ovf_flag", overflow, 1);
        check_addrs("ovf", 21'h004000, 7);
        check("ovf_words", got_data.size(), 112);
        for (int i = 0; i < got_data.size() && i < 112; i++) begin
            check($sformatf("ovf_word%0d", i), got_data[i], exp_word(0, -1, (i < 64) ? i : i + 6));
        end

        // Start while busy is ignored
        got_data.delete();
        got_addr.delete();
        start_run(21'h000300, 32);
        fork
            drive_samples(32, 'h100, -1, -1);
            begin
                repeat (40) @(negedge clk_PSRAM);
                base_addr   = 21'h000700;
                num_samples = CNT_W'(16);
                start       = 1'b1;
                @(negedge clk_PSRAM);
                start       = 1'b0;
                #1;
                check("sbusy_busy_held", busy, 1);
            end
        join
        wait_done("sbusy");
        check_addrs("sbusy", 21'h000300, 2);
        check("sbusy_words", got_data.size(), 32);
        for (int i = 0; i < got_data.size() && i < 32; i++) begin
            check($sformatf("sbusy_word%0d", i), got_data[i], exp_word('h100, -1, i));
        end

        // Reset after 5 pops of the first burst
        got_data.delete();
        got_addr.delete();
        start_run(21'h000500, 32);
        fork
            drive_samples(32, 0, -1, -1);
            begin
                n = 0;
                while (got_data.size() < 5 && n < 2000) begin
                    @(negedge clk_PSRAM);
                    n++;
                end
                check("mrst_reached_pops", got_data.size(), 5);
                @(posedge clk_PSRAM);
                #2;
                rst_n = 1'b0;
                #1;
                check("mrst_wr_req",   wr_bus.wr_req,  0);
                check("mrst_wr_addr",  wr_bus.wr_addr, 0);
                check("mrst_wr_data",  wr_bus.wr_data, 0);
                check("mrst_busy",     busy,           0);
                check("mrst_done",     done,           0);
                check("mrst_overflow", overflow,       0);
                repeat (3) @(negedge clk_PSRAM);
                rst_n = 1'b1;
                saw_req = 1'b0;
                repeat (150) begin
                    @(negedge clk_PSRAM);
                    if (wr_bus.wr_req) saw_req = 1'b1;
                end
                check("mrst_no_req", saw_req, 0);
                check("mrst_idle_busy", busy, 0);
            end
        join

        // A fresh run after reset starts from its own base address
        run_vector(vecs[4], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
